// File: rtl/hazard_perf_counter.sv
// Hazard-control performance counters with a registered, address-indexed readback port.
// Optional forwarding counters (addresses 5-7) are built only when PERF_FWD_CNT_EN is defined.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             clr,
  input  logic             PC_EN_IF,
  input  logic             reg_FD_stall,
  input  logic             reg_FD_flush,
  input  logic             reg_DE_flush,
  input  logic [1:0]       forward_ctrl_A,
  input  logic [1:0]       forward_ctrl_B,
  input  logic             forward_ctrl_ls,
  input  logic [2:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             sat_flag
);
  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cyc_q, cyc_d, stc_q, stc_d, sev_q, sev_d, brf_q, brf_d;
  logic [CNT_W-1:0] max_q, max_d, run_q, run_d, rd_q, rd_d;
  logic             prev_q, prev_d, sat_q, sat_d;
  logic [CNT_W:0]   r;
  logic [CNT_W-1:0] run_n;
  logic             hit, rise;

  // Returns {hit, value}: value clamps at all-ones, hit flags that the add landed on all-ones.
  function automatic logic [CNT_W:0] sadd(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (s[CNT_W]) s[CNT_W-1:0] = ONES;
    return {(inc != 2'd0) && (s[CNT_W-1:0] == ONES), s[CNT_W-1:0]};
  endfunction

`ifdef PERF_FWD_CNT_EN
  logic [CNT_W-1:0] ex_q, ex_d, mem_q, mem_d, ls_q, ls_d;
  logic [1:0]       ex_inc, mem_inc;
  logic             unused_ok;
  assign unused_ok = ^{PC_EN_IF, reg_DE_flush};
`else
  logic             unused_ok;
  assign unused_ok = ^{PC_EN_IF, reg_DE_flush, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls};
`endif

  always_comb begin
    cyc_d = cyc_q; stc_d = stc_q; sev_d = sev_q; brf_d = brf_q;
    max_d = max_q; run_d = run_q; prev_d = prev_q; sat_d = sat_q;
    rd_d  = '0;
    r     = '0;
    hit   = 1'b0;
    run_n = run_q;
    rise  = reg_FD_stall & ~prev_q;
`ifdef PERF_FWD_CNT_EN
    ex_d = ex_q; mem_d = mem_q; ls_d = ls_q;
    ex_inc  = {1'b0, forward_ctrl_A == 2'b01} + {1'b0, forward_ctrl_B == 2'b01};
    mem_inc = {1'b0, forward_ctrl_A[1]} + {1'b0, forward_ctrl_B[1]};
`endif
    if (clr) begin
      cyc_d = '0; stc_d = '0; sev_d = '0; brf_d = '0;
      max_d = '0; run_d = '0; prev_d = 1'b0; sat_d = 1'b0;
`ifdef PERF_FWD_CNT_EN
      ex_d = '0; mem_d = '0; ls_d = '0;
`endif
    end else begin
      case (rd_addr)
        3'd0: rd_d = cyc_q;
        3'd1: rd_d = stc_q;
        3'd2: rd_d = sev_q;
        3'd3: rd_d = brf_q;
        3'd4: rd_d = max_q;
`ifdef PERF_FWD_CNT_EN
        3'd5: rd_d = ex_q;
        3'd6: rd_d = mem_q;
        3'd7: rd_d = ls_q;
`endif
        default: rd_d = '0;
      endcase
      if (cnt_en) begin
        r = sadd(cyc_q, 2'd1);                  cyc_d = r[CNT_W-1:0]; hit = hit | r[CNT_W];
        r = sadd(stc_q, {1'b0, reg_FD_stall});  stc_d = r[CNT_W-1:0]; hit = hit | r[CNT_W];
        r = sadd(sev_q, {1'b0, rise});          sev_d = r[CNT_W-1:0]; hit = hit | r[CNT_W];
        r = sadd(brf_q, {1'b0, reg_FD_flush});  brf_d = r[CNT_W-1:0]; hit = hit | r[CNT_W];
        if (!reg_FD_stall)  run_n = '0;
        else if (rise)      run_n = ONE;
        else begin
          r = sadd(run_q, 2'd1);
          run_n = r[CNT_W-1:0];
        end
        run_d  = run_n;
        prev_d = reg_FD_stall;
        if (run_n > max_q) begin
          max_d = run_n;
          hit   = hit | (run_n == ONES);
        end
`ifdef PERF_FWD_CNT_EN
        r = sadd(ex_q, ex_inc);                   ex_d  = r[CNT_W-1:0]; hit = hit | r[CNT_W];
        r = sadd(mem_q, mem_inc);                 mem_d = r[CNT_W-1:0]; hit = hit | r[CNT_W];
        r = sadd(ls_q, {1'b0, forward_ctrl_ls});  ls_d  = r[CNT_W-1:0]; hit = hit | r[CNT_W];
`endif
        sat_d = sat_q | hit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0; stc_q <= '0; sev_q <= '0; brf_q <= '0;
      max_q <= '0; run_q <= '0; prev_q <= 1'b0; sat_q <= 1'b0; rd_q <= '0;
`ifdef PERF_FWD_CNT_EN
      ex_q <= '0; mem_q <= '0; ls_q <= '0;
`endif
    end else begin
      cyc_q <= cyc_d; stc_q <= stc_d; sev_q <= sev_d; brf_q <= brf_d;
      max_q <= max_d; run_q <= run_d; prev_q <= prev_d; sat_q <= sat_d; rd_q <= rd_d;
`ifdef PERF_FWD_CNT_EN
      ex_q <= ex_d; mem_q <= mem_d; ls_q <= ls_d;
`endif
    end
  end

  assign rd_data  = rd_q;
  assign sat_flag = sat_q;
endmodule

// File: tb/tb_hazard_perf_counter.sv
// Directed bench for hazard_perf_counter: a 32-bit and an 8-bit instance share all stimulus.
module tb_hazard_perf_counter;
  logic        clk, rst, cnt_en, clr, pc_en, fd_stall, fd_flush, de_flush, fls;
  logic [1:0]  fa, fb;
  logic [2:0]  rd_addr;
  logic [31:0] rd32;
  logic [7:0]  rd8;
  logic        sat32, sat8;
  int          total, bad;

  hazard_perf_counter #(.CNT_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .cnt_en(cnt_en), .clr(clr), .PC_EN_IF(pc_en),
    .reg_FD_stall(fd_stall), .reg_FD_flush(fd_flush), .reg_DE_flush(de_flush),
    .forward_ctrl_A(fa), .forward_ctrl_B(fb), .forward_ctrl_ls(fls),
    .rd_addr(rd_addr), .rd_data(rd32), .sat_flag(sat32));

  hazard_perf_counter #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .cnt_en(cnt_en), .clr(clr), .PC_EN_IF(pc_en),
    .reg_FD_stall(fd_stall), .reg_FD_flush(fd_flush), .reg_DE_flush(de_flush),
    .forward_ctrl_A(fa), .forward_ctrl_B(fb), .forward_ctrl_ls(fls),
    .rd_addr(rd_addr), .rd_data(rd8), .sat_flag(sat8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge and are sampled by the following rising edge.
  task automatic drv(input logic en, input logic st, input logic fl,
                     input logic [1:0] a, input logic [1:0] b, input logic l);
    @(negedge clk);
    cnt_en = en; fd_stall = st; de_flush = st; pc_en = ~st;
    fd_flush = fl; fa = a; fb = b; fls = l;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1; cnt_en = 1'b0; fd_stall = 1'b0; de_flush = 1'b0; pc_en = 1'b1;
    fd_flush = 1'b0; fa = 2'b00; fb = 2'b00; fls = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (rd32 !== 32'd0 || sat32 !== 1'b0 || rd8 !== 8'd0 || sat8 !== 1'b0) begin
      bad++; $display("FAIL reset: rd32=%0d sat32=%0b rd8=%0d sat8=%0b want 0", rd32, sat32, rd8, sat8);
    end
  endtask

  task automatic test_cycles();
    logic [31:0] exp;
    for (int i = 0; i < 10; i++) drv(1, 0, 0, 2'b00, 2'b00, 0);
    drv(0, 0, 0, 2'b00, 2'b00, 0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      exp = (a == 0) ? 32'd10 : 32'd0;
      total++;
      if (rd32 !== exp) begin bad++; $display("FAIL cycles addr%0d: got %0d want %0d", a, rd32, exp); end
    end
    total++;
    if (sat32 !== 1'b0) begin bad++; $display("FAIL cycles sat: got %0b want 0", sat32); end
  endtask

  task automatic test_stall();
    logic [6:0] pat;
    pat = 7'b1110010;
    do_clr();
    for (int i = 6; i >= 0; i--) drv(1, pat[i], 0, 2'b00, 2'b00, 0);
    drv(0, 0, 0, 2'b00, 2'b00, 0);
    rd(3'd1); total++; if (rd32 !== 32'd4) begin bad++; $display("FAIL stall_cyc: got %0d want 4", rd32); end
    rd(3'd2); total++; if (rd32 !== 32'd2) begin bad++; $display("FAIL stall_evt: got %0d want 2", rd32); end
    rd(3'd4); total++; if (rd32 !== 32'd3) begin bad++; $display("FAIL max_run: got %0d want 3", rd32); end
    rd(3'd0); total++; if (rd32 !== 32'd7) begin bad++; $display("FAIL stall_cyc_total: got %0d want 7", rd32); end
  endtask

  task automatic test_fwd();
    logic [31:0] e_ex, e_mem, e_ls;
`ifdef PERF_FWD_CNT_EN
    e_ex = 32'd2; e_mem = 32'd2; e_ls = 32'd1;
`else
    e_ex = 32'd0; e_mem = 32'd0; e_ls = 32'd0;
`endif
    do_clr();
    drv(1, 0, 0, 2'b01, 2'b01, 0);
    drv(1, 0, 0, 2'b11, 2'b10, 0);
    drv(1, 0, 0, 2'b00, 2'b00, 1);
    drv(0, 0, 0, 2'b00, 2'b00, 0);
    rd(3'd5); total++; if (rd32 !== e_ex)  begin bad++; $display("FAIL fwd_ex: got %0d want %0d", rd32, e_ex); end
    rd(3'd6); total++; if (rd32 !== e_mem) begin bad++; $display("FAIL fwd_mem: got %0d want %0d", rd32, e_mem); end
    rd(3'd7); total++; if (rd32 !== e_ls)  begin bad++; $display("FAIL fwd_ls: got %0d want %0d", rd32, e_ls); end
  endtask

  task automatic test_saturate();
    do_clr();
    for (int i = 0; i < 300; i++) drv(1, 1, 0, 2'b00, 2'b00, 0);
    drv(0, 0, 0, 2'b00, 2'b00, 0);
    rd(3'd4);
    total++; if (rd8 !== 8'd255)   begin bad++; $display("FAIL sat8_max_run: got %0d want 255", rd8); end
    total++; if (rd32 !== 32'd300) begin bad++; $display("FAIL w32_max_run: got %0d want 300", rd32); end
    rd(3'd2);
    total++; if (rd8 !== 8'd1)     begin bad++; $display("FAIL sat8_evt: got %0d want 1", rd8); end
    rd(3'd1);
    total++; if (rd8 !== 8'd255)   begin bad++; $display("FAIL sat8_stall_cyc: got %0d want 255", rd8); end
    total++; if (rd32 !== 32'd300) begin bad++; $display("FAIL w32_stall_cyc: got %0d want 300", rd32); end
    total++; if (sat8 !== 1'b1 || sat32 !== 1'b0) begin
      bad++; $display("FAIL sat_flags: got sat8=%0b sat32=%0b want 1/0", sat8, sat32);
    end
    do_clr();
    total++; if (rd8 !== 8'd0 || sat8 !== 1'b0) begin
      bad++; $display("FAIL read_after_clr: got rd8=%0d sat8=%0b want 0/0", rd8, sat8);
    end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      total++; if (rd8 !== 8'd0) begin bad++; $display("FAIL clr8 addr%0d: got %0d want 0", a, rd8); end
    end
  endtask

  task automatic test_freeze();
    do_clr();
    for (int i = 0; i < 3; i++) drv(1, 1, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 5; i++) drv(0, 1, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 2; i++) drv(1, 1, 0, 2'b00, 2'b00, 0);
    drv(1, 0, 0, 2'b00, 2'b00, 0);
    drv(0, 0, 0, 2'b00, 2'b00, 0);
    rd(3'd2); total++; if (rd32 !== 32'd1) begin bad++; $display("FAIL freeze_evt: got %0d want 1", rd32); end
    rd(3'd4); total++; if (rd32 !== 32'd5) begin bad++; $display("FAIL freeze_max_run: got %0d want 5", rd32); end
    rd(3'd1); total++; if (rd32 !== 32'd5) begin bad++; $display("FAIL freeze_stall_cyc: got %0d want 5", rd32); end
  endtask

  task automatic test_flush_clr();
    do_clr();
    drv(1, 0, 1, 2'b00, 2'b00, 0);
    drv(1, 0, 1, 2'b00, 2'b00, 0);
    drv(0, 0, 0, 2'b00, 2'b00, 0);
    rd(3'd3); total++; if (rd32 !== 32'd2) begin bad++; $display("FAIL br_flush: got %0d want 2", rd32); end
    @(negedge clk);
    clr = 1'b1; cnt_en = 1'b1; fd_flush = 1'b1;
    @(negedge clk);
    clr = 1'b0; cnt_en = 1'b0; fd_flush = 1'b0;
    rd(3'd3); total++; if (rd32 !== 32'd0) begin bad++; $display("FAIL flush_clr: got %0d want 0", rd32); end
    rd(3'd0); total++; if (rd32 !== 32'd0) begin bad++; $display("FAIL clr_over_en: got %0d want 0", rd32); end
  endtask

  task automatic test_rst_mid_stall();
    do_clr();
    rd(3'd1);
    for (int i = 0; i < 4; i++) drv(1, 1, 0, 2'b00, 2'b00, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (rd32 !== 32'd0 || sat32 !== 1'b0 || rd8 !== 8'd0) begin
      bad++; $display("FAIL async_rst: got rd32=%0d sat32=%0b rd8=%0d want 0", rd32, sat32, rd8);
    end
    @(negedge clk);
    rst = 1'b0;
    drv(1, 1, 0, 2'b00, 2'b00, 0);
    drv(0, 0, 0, 2'b00, 2'b00, 0);
    rd(3'd2); total++; if (rd32 !== 32'd1) begin bad++; $display("FAIL rst_new_evt: got %0d want 1", rd32); end
    rd(3'd1); total++; if (rd32 !== 32'd2) begin bad++; $display("FAIL rst_stall_cyc: got %0d want 2", rd32); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; clr = 1'b0; cnt_en = 1'b0; pc_en = 1'b1; fd_stall = 1'b0; fd_flush = 1'b0;
    de_flush = 1'b0; fa = 2'b00; fb = 2'b00; fls = 1'b0; rd_addr = 3'd0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_cycles();
    test_stall();
    test_fwd();
    test_saturate();
    test_freeze();
    test_flush_clr();
    test_rst_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
